// File: rtl/fan_btn_pkg.sv
// Shared types and default timing for the push-button gesture classifier.
// Defaults assume a 100 MHz system clock.
package fan_btn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        PRESSED_2 = 3'd4
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 100_000_000;
    localparam int DEF_DCLICK_CYC   = 30_000_000;
    localparam int DEF_ACTIVE_LOW   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_press_classifier_if.sv
// Button pin plus the debounced level, gesture pulses and busy flag.
// master = classifier side, slave = consumer/driver side.
interface btn_press_classifier_if;
    logic btn_raw;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    modport master (
        input  btn_raw,
        output btn_level,
        output short_press,
        output long_press,
        output double_click,
        output busy
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  short_press,
        input  long_press,
        input  double_click,
        input  busy
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, polarity normalisation and level debouncer.
// btn_level_o is 1 while pressed; a clean pin edge reaches it DEBOUNCE_CYC+2 cycles later.
module btn_debounce
    import fan_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic btn_level_o
);

    localparam int   CNT_W      = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic ACT_LOW_L  = (ACTIVE_LOW != 0);
    // The first differing cycle clears the counter, so the flip happens at count DEBOUNCE_CYC-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 2);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed;

    assign pressed = sync2_q ^ ACT_LOW_L;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if ((pressed != level_q) && (pressed == prev_q)) begin
            if (cnt_q == CNT_LAST) begin
                level_d = pressed;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= ACT_LOW_L;
            sync2_q <= ACT_LOW_L;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            prev_q  <= pressed;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level_o = level_q;

endmodule

// File: rtl/btn_press_classifier.sv
// Gesture classifier: turns a debounced button into short/long/double-click pulses.
// Each pulse is registered and lasts exactly one cycle; at most one is high at a time.
module btn_press_classifier
    import fan_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int DCLICK_CYC   = DEF_DCLICK_CYC,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    btn_press_classifier_if.master bus
);

    localparam int GCNT_W = $clog2(max_int(LONG_CYC, DCLICK_CYC)) + 1;
    localparam logic [GCNT_W-1:0] LONG_LAST   = GCNT_W'(LONG_CYC - 1);
    localparam logic [GCNT_W-1:0] DCLICK_LAST = GCNT_W'(DCLICK_CYC - 1);

    logic              level;
    logic              level_prev_q;
    logic              press_evt;
    logic              release_evt;
    btn_state_e        state_q;
    btn_state_e        state_d;
    logic [GCNT_W-1:0] gcnt_q;
    logic [GCNT_W-1:0] gcnt_d;
    logic [GCNT_W-1:0] gcnt_inc;
    logic              long_hit;
    logic              dclick_hit;
    logic              short_q;
    logic              short_d;
    logic              long_q;
    logic              long_d;
    logic              dbl_q;
    logic              dbl_d;
    logic              busy_q;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw_i   (bus.btn_raw),
        .btn_level_o (level)
    );

    assign press_evt   = level & ~level_prev_q;
    assign release_evt = ~level & level_prev_q;

    // Saturating increment; a limit "hit" means this edge would bring the counter to it.
    assign gcnt_inc   = (gcnt_q == '1) ? gcnt_q : gcnt_q + GCNT_W'(1);
    assign long_hit   = (gcnt_inc == LONG_LAST);
    assign dclick_hit = (gcnt_inc == DCLICK_LAST);

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_evt) state_d = PRESSED;
            end
            PRESSED: begin
                if (release_evt) begin
                    state_d = WAIT_2ND;
                end else if (long_hit) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (release_evt) state_d = IDLE;
            end
            WAIT_2ND: begin
                // A press on the timeout cycle still counts as the second click.
                if (press_evt) begin
                    state_d = PRESSED_2;
                end else if (dclick_hit) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESSED_2: begin
                if (release_evt) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end else if (long_hit) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gcnt_d = (state_d != state_q) ? '0 : gcnt_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gcnt_q       <= '0;
            level_prev_q <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            dbl_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gcnt_q       <= gcnt_d;
            level_prev_q <= level;
            short_q      <= short_d;
            long_q       <= long_d;
            dbl_q        <= dbl_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.btn_level    = level;
    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_click = dbl_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier with short timing constants.
// Expected latencies and pulse counts are hand-derived constants.
module tb_btn_press_classifier;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    btn_press_classifier_if bus_if ();

    btn_press_classifier #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .DCLICK_CYC   (10),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int   rise_n = 0, rise_cyc = 0, fall_cyc = 0;
    int   short_n = 0, long_n = 0, dbl_n = 0;
    int   short_cyc = 0, long_cyc = 0, dbl_cyc = 0;
    int   multi_n = 0;
    logic lvl_prev = 1'b0;

    always @(negedge clk) begin
        if (bus_if.btn_level && !lvl_prev) begin
            rise_n   = rise_n + 1;
            rise_cyc = cyc;
        end
        if (!bus_if.btn_level && lvl_prev) fall_cyc = cyc;
        lvl_prev = bus_if.btn_level;
        if (bus_if.short_press === 1'b1) begin
            short_n   = short_n + 1;
            short_cyc = cyc;
        end
        if (bus_if.long_press === 1'b1) begin
            long_n   = long_n + 1;
            long_cyc = cyc;
        end
        if (bus_if.double_click === 1'b1) begin
            dbl_n   = dbl_n + 1;
            dbl_cyc = cyc;
        end
        if (int'(bus_if.short_press) + int'(bus_if.long_press) + int'(bus_if.double_click) > 1)
            multi_n = multi_n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s0, l0, d0, r0, p, r, q;

    task automatic snap();
        s0 = short_n;
        l0 = long_n;
        d0 = dbl_n;
        r0 = rise_n;
    endtask

    initial begin
        bus_if.btn_raw = 1'b1;
        #2 reset_n = 1'b0;
        tick(3);
        chk("rst_level", int'(bus_if.btn_level), 0);
        chk("rst_busy",  int'(bus_if.busy), 0);
        chk("rst_short", int'(bus_if.short_press), 0);
        chk("rst_long",  int'(bus_if.long_press), 0);
        chk("rst_dbl",   int'(bus_if.double_click), 0);
        reset_n = 1'b1;
        tick(5);
        $display("txn reset done cyc=%0d", cyc);

        // Glitch train: 2-cycle runs never qualify
        snap();
        for (int i = 0; i < 3; i++) begin
            bus_if.btn_raw = 1'b0;
            tick(2);
            bus_if.btn_raw = 1'b1;
            tick(2);
        end
        tick(20);
        chk("glitch_rise",   rise_n - r0, 0);
        chk("glitch_pulses", (short_n - s0) + (long_n - l0) + (dbl_n - d0), 0);
        chk("glitch_level",  int'(bus_if.btn_level), 0);
        $display("txn glitch done cyc=%0d", cyc);

        // Short press
        snap();
        p = cyc;
        bus_if.btn_raw = 1'b0;
        tick(8);
        r = cyc;
        chk("short_busy_held", int'(bus_if.busy), 1);
        bus_if.btn_raw = 1'b1;
        tick(30);
        chk("short_rise_lat",  rise_cyc - p, 6);
        chk("short_fall_lat",  fall_cyc - r, 6);
        chk("short_count",     short_n - s0, 1);
        chk("short_pulse_lat", short_cyc - fall_cyc, 10);
        chk("short_others",    (long_n - l0) + (dbl_n - d0), 0);
        chk("short_busy_end",  int'(bus_if.busy), 0);
        $display("txn short_press done cyc=%0d", cyc);

        // Long press held 30 cycles
        snap();
        bus_if.btn_raw = 1'b0;
        tick(30);
        bus_if.btn_raw = 1'b1;
        tick(30);
        chk("long_count",     long_n - l0, 1);
        chk("long_pulse_lat", long_cyc - rise_cyc, 20);
        chk("long_others",    (short_n - s0) + (dbl_n - d0), 0);
        chk("long_busy_end",  int'(bus_if.busy), 0);
        $display("txn long_press done cyc=%0d", cyc);

        // Double click 5/5/5
        snap();
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(5);
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(30);
        chk("dbl_count",     dbl_n - d0, 1);
        chk("dbl_pulse_lat", dbl_cyc - fall_cyc, 1);
        chk("dbl_no_short",  short_n - s0, 0);
        $display("txn double_click done cyc=%0d", cyc);

        // Second press lands on the WAIT_2ND timeout cycle: press wins
        snap();
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(9);
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(30);
        chk("edge9_no_short", short_n - s0, 0);
        chk("edge9_dbl",      dbl_n - d0, 1);
        $display("txn dclick_edge_press done cyc=%0d", cyc);

        // One cycle later: window already closed, two separate short presses
        snap();
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(10);
        bus_if.btn_raw = 1'b0; tick(5);
        bus_if.btn_raw = 1'b1; tick(40);
        chk("late_shorts", short_n - s0, 2);
        chk("late_no_dbl", dbl_n - d0, 0);
        $display("txn dclick_late_press done cyc=%0d", cyc);

        // Reset mid-PRESSED, button still held across reset release
        snap();
        bus_if.btn_raw = 1'b0;
        tick(19);
        chk("rstmid_busy_before", int'(bus_if.busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_level", int'(bus_if.btn_level), 0);
        chk("rstmid_busy",  int'(bus_if.busy), 0);
        chk("rstmid_pulse", int'(bus_if.short_press) + int'(bus_if.long_press) + int'(bus_if.double_click), 0);
        tick(3);
        reset_n = 1'b1;
        q = cyc;
        tick(14);
        bus_if.btn_raw = 1'b1;
        tick(30);
        chk("rstmid_requal_lat", rise_cyc - q, 6);
        chk("rstmid_short",      short_n - s0, 1);
        chk("rstmid_no_long",    long_n - l0, 0);
        chk("rstmid_no_dbl",     dbl_n - d0, 0);
        $display("txn reset_mid_gesture done cyc=%0d", cyc);

        chk("pulses_onehot", multi_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_press_classifier.md
Name: btn_press_classifier

Overview:
- Sits between a raw push-button pin and the fan control FSM. Replaces the bare edge-pulse path for buttons that need gesture decoding.
- Synchronises the pin, debounces it, and derives press/release events internally.
- Classifies each gesture as short press, long press or double click, and emits one single-cycle pulse per gesture.
- The fan mode logic consumes these pulses directly.

Parameters:
- DEBOUNCE_CYC, 1_000_000, clock cycles a new input level must be stable before it is accepted (10 ms at 100 MHz).
- LONG_CYC, 100_000_000, cycles of continuous hold that make a long press (1 s).
- DCLICK_CYC, 30_000_000, maximum release gap after a short press in which a second press forms a double click (300 ms).
- ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed (pull-up wiring); 0 means the pin reads 1 when pressed.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- btn_raw, input, 1, raw button pin, asynchronous to clk.
- btn_level, output, 1, debounced level; 1 = pressed.
- short_press, output, 1, one-cycle pulse: single short press confirmed.
- long_press, output, 1, one-cycle pulse: hold reached LONG_CYC.
- double_click, output, 1, one-cycle pulse: second short press completed.
- busy, output, 1, 1 whenever the FSM is not IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Sync flops load the "released" level.
  - Debounce counter = 0, btn_level = 0, all pulses = 0, busy = 0, FSM = IDLE, gesture counter = 0.
  - Reset asserted mid-gesture aborts the gesture; no pulse is emitted on release of reset.
- Input path:
  - 2-flop synchroniser, then polarity normalisation (invert if ACTIVE_LOW).
  - Debounce: counter clears whenever the synced value equals btn_level or differs but changed from the previous cycle. btn_level flips only after DEBOUNCE_CYC consecutive cycles of the differing value.
  - A glitch shorter than DEBOUNCE_CYC leaves btn_level unchanged.
  - Latency: clean raw edge to btn_level edge = DEBOUNCE_CYC+2 cycles.
- Events: press = btn_level 1 with previous-cycle btn_level 0; release = the inverse. Events are combinational from registered values.
- Gesture counter: width $clog2(max(LONG_CYC,DCLICK_CYC))+1; cleared on every state change; saturates and never wraps.
- FSM:
  - IDLE: press -> PRESSED.
  - PRESSED: counter counts while held. If counter reaches LONG_CYC-1 while held -> LONG_HELD and long_press pulses. On release -> WAIT_2ND.
  - LONG_HELD: release -> IDLE. No further pulses, regardless of hold length (no auto-repeat).
  - WAIT_2ND: counter counts. If press occurs before counter reaches DCLICK_CYC-1 -> PRESSED_2. If counter reaches DCLICK_CYC-1 with no press -> IDLE and short_press pulses. If both happen in the same cycle, press wins (-> PRESSED_2, no short_press).
  - PRESSED_2: release -> IDLE and double_click pulses. Hold reaching LONG_CYC-1 -> LONG_HELD and long_press pulses; the first short press is discarded.
- Pulses are registered: high exactly one cycle, in the cycle after the transition condition. At most one of short_press, long_press or double_click is high in any cycle.
- busy = (state != IDLE), registered with the state.
- Parameter legality: all three parameters >= 2, else the behaviour is undefined.

Decomposition:
- Package fan_btn_pkg holds:
  - FSM state typedef: IDLE, PRESSED, LONG_HELD, WAIT_2ND, PRESSED_2 (3-bit encoding).
  - Default timing constants for 100 MHz.
- One natural sub-module, btn_debounce: synchroniser + polarity + debounce counter, output btn_level.
- The classifier FSM and gesture counter stay in the top module.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20, DCLICK_CYC=10, ACTIVE_LOW=1):
- Raw pin toggles low/high every 2 cycles for 12 cycles, then returns high -> btn_level stays 0 throughout, and no pulses occur.
- Press held 8 cycles, then release, then idle -> btn_level rises 6 cycles after the press and falls 6 cycles after the release; exactly one short_press pulse 10 cycles after the btn_level fall. busy is 1 from press detection until that pulse.
- Press held 30 cycles -> long_press pulses once, 20 cycles after the btn_level rise; no pulse on release.
- Press 5 cycles, release 5 cycles, press 5 cycles, release -> one double_click pulse one cycle after the second btn_level fall; no short_press.
- Press, release, then second press landing exactly when the WAIT_2ND counter hits 9 -> FSM enters PRESSED_2 and short_press stays 0.
- reset_n pulled low mid-PRESSED (counter at 12), released while the button is still held -> all outputs 0 and btn_level 0 immediately. After release of reset, btn_level re-qualifies and a fresh gesture starts from IDLE.
